// File: rtl/pmem_responder_pkg.sv
// Shared types for the pmem responder: line/index types, FSM state and default latency.
package pmem_responder_pkg;

   typedef logic [127:0] lc3b_line;
   typedef logic [11:0]  lc3b_line_index;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} pmem_state_t;

   localparam int PMEM_DEFAULT_LATENCY = 4;
   localparam int PMEM_CNT_W           = 4;

endpackage

// File: rtl/pmem_line_array.sv
// Line-granular backing store: synchronous write, combinational read. Contents are never reset.
module pmem_line_array
   import pmem_responder_pkg::*;
#(
   parameter int INDEX_BITS = 12
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [INDEX_BITS-1:0] widx,
   input  lc3b_line              wdata,
   input  logic [INDEX_BITS-1:0] ridx,
   output lc3b_line              rdata
);

   lc3b_line mem [2**INDEX_BITS];

   always_ff @(posedge clk) begin
      if (we) mem[widx] <= wdata;
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency physical memory responder for the cache pmem port.
// Define PMEM_ERROR_CHECK_EN to enable the sticky pmem_error protocol checker.
module pmem_responder
   import pmem_responder_pkg::*;
#(
   parameter int LATENCY    = PMEM_DEFAULT_LATENCY,
   parameter int INDEX_BITS = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pmem_read,
   input  logic          pmem_write,
   input  logic [15:0]   pmem_address,
   input  logic [127:0]  pmem_wdata,
   output logic [127:0]  pmem_rdata,
   output logic          pmem_resp,
   output logic          pmem_error
);

   localparam logic [PMEM_CNT_W-1:0] LAT_M1 = PMEM_CNT_W'(LATENCY - 1);

   pmem_state_t             state_q, state_d;
   logic [PMEM_CNT_W-1:0]   cnt_q, cnt_d;
   logic [INDEX_BITS-1:0]   idx_q, idx_d;
   logic                    wr_q, wr_d;
   lc3b_line                wdata_q, wdata_d;
   lc3b_line                rdata_q, rdata_d;

   logic [INDEX_BITS-1:0]   addr_idx;
   logic                    req_held;
   logic                    arr_we;
   lc3b_line                arr_rdata;
   logic                    unused_addr_bits;

   assign addr_idx         = pmem_address[INDEX_BITS+3:4];
   assign unused_addr_bits = ^pmem_address;
   assign req_held         = wr_q ? pmem_write : pmem_read;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (pmem_read || pmem_write) begin
               idx_d   = addr_idx;
               wr_d    = pmem_write;
               wdata_d = pmem_wdata;
               cnt_d   = LAT_M1;
               state_d = (LATENCY == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            if (!req_held) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q <= PMEM_CNT_W'(1)) begin
               // counter reaches 0 on the same edge that enters RESP
               cnt_d   = '0;
               state_d = RESP;
            end else begin
               cnt_d   = cnt_q - PMEM_CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Capture read data on entry to RESP so pmem_rdata is a flop output that holds afterwards.
      if (state_d == RESP && !wr_d) rdata_d = arr_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign arr_we     = (state_q == RESP) && wr_q && !reset;
   assign pmem_resp  = (state_q == RESP);
   assign pmem_rdata = rdata_q;

   pmem_line_array #(.INDEX_BITS(INDEX_BITS)) u_array (
      .clk   (clk),
      .we    (arr_we),
      .widx  (idx_q),
      .wdata (wdata_q),
      .ridx  (idx_d),
      .rdata (arr_rdata)
   );

`ifdef PMEM_ERROR_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (state_q == IDLE && pmem_read && pmem_write) err_d = 1'b1;
      if (state_q == BUSY && (!req_held || addr_idx != idx_q)) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign pmem_error = err_q;
`else
   assign pmem_error = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized self-checking bench for pmem_responder against a line-map reference model.
module tb_pmem_responder;

   localparam int LAT = 4;
`ifdef PMEM_ERROR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp, pmem_error;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_resp_cyc = -1000;

   logic [127:0] mem_m [int];
   logic [127:0] last_rd;
   bit           err_exp;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pmem_responder #(.LATENCY(LAT), .INDEX_BITS(12)) dut (
      .clk          (clk),
      .reset        (reset),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .pmem_error   (pmem_error)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at a negedge; returns at a negedge one cycle after the response.
   task automatic txn(input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [127:0] wd, input bit scramble);
      int n;
      bit seen;
      int idx;
      logic [15:0] a;
      idx = int'(addr[15:4]);
      pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd;
      if (rd && wr && ERR_EN) err_exp = 1'b1;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (pmem_resp) seen = 1'b1;
         else if (scramble) begin
            a = 16'($urandom);
            pmem_address = a;
            pmem_wdata   = rnd128();
            if (int'(a[15:4]) != idx && ERR_EN) err_exp = 1'b1;
         end
      end
      chk("resp_seen", 128'(seen), 128'(1));
      if (seen) begin
         chk("latency", 128'(n), 128'(LAT));
         chk("gap", 128'(cyc - last_resp_cyc >= LAT + 1), 128'(1));
         last_resp_cyc = cyc;
         if (wr) begin
            mem_m[idx] = wd;
            chk("rdata_hold", pmem_rdata, last_rd);
         end else if (mem_m.exists(idx)) begin
            chk("rdata", pmem_rdata, mem_m[idx]);
            last_rd = mem_m[idx];
         end
         chk("error", 128'(pmem_error), 128'(err_exp));
      end
      pmem_read = 1'b0; pmem_write = 1'b0;
      @(negedge clk);
      chk("resp_pulse", 128'(pmem_resp), 128'(0));
   endtask

   task automatic do_reset();
      reset = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      last_rd = '0;
      err_exp = 1'b0;
      chk("rst_rdata", pmem_rdata, 128'(0));
      chk("rst_resp", 128'(pmem_resp), 128'(0));
      chk("rst_error", 128'(pmem_error), 128'(0));
   endtask

   initial begin
      int any_resp;
      bit rd, wr;
      logic [15:0] addr;
      reset = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0;
      pmem_address = '0; pmem_wdata = '0;
      last_rd = '0; err_exp = 1'b0;
      repeat (3) @(negedge clk);
      do_reset();

      // write-then-read with offset bits ignored
      txn(0, 1, 16'h0120, 128'h00112233445566778899AABBCCDDEEFF, 0);
      txn(1, 0, 16'h012A, '0, 0);

      // write-back then allocate-read of a different line
      txn(0, 1, 16'h0540, 128'hBBBB_0000_1111_2222_3333_4444_5555_6666, 0);
      txn(0, 1, 16'h0340, 128'hAAAA_9999_8888_7777_6666_5555_4444_3333, 0);
      txn(1, 0, 16'h0540, '0, 0);
      txn(1, 0, 16'h0340, '0, 0);

      // abort: read dropped after two cycles
      pmem_read = 1'b1; pmem_address = 16'h0100;
      any_resp = 0;
      repeat (2) begin @(negedge clk); any_resp += int'(pmem_resp); end
      pmem_read = 1'b0;
      repeat (LAT + 3) begin @(negedge clk); any_resp += int'(pmem_resp); end
      chk("abort_noresp", 128'(any_resp), 128'(0));
      if (ERR_EN) err_exp = 1'b1;
      chk("abort_error", 128'(pmem_error), 128'(err_exp));
      txn(1, 0, 16'h0125, '0, 0);
      do_reset();

      // reset in the middle of a write discards it
      txn(0, 1, 16'h0200, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 0);
      pmem_write = 1'b1; pmem_address = 16'h0200; pmem_wdata = 128'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0;
      any_resp = 0;
      repeat (2) begin @(negedge clk); any_resp += int'(pmem_resp); end
      reset = 1'b1; pmem_write = 1'b0;
      repeat (2) begin @(negedge clk); any_resp += int'(pmem_resp); end
      reset = 1'b0; last_rd = '0; err_exp = 1'b0;
      repeat (LAT) begin @(negedge clk); any_resp += int'(pmem_resp); end
      chk("rstmid_noresp", 128'(any_resp), 128'(0));
      txn(1, 0, 16'h0200, '0, 0);

      // simultaneous read+write: write wins, rdata unchanged
      txn(1, 1, 16'h0030, 128'hDDDD_EEEE_DDDD_EEEE_DDDD_EEEE_DDDD_EEEE, 0);
      txn(1, 0, 16'h0030, '0, 0);
      do_reset();

      // randomized traffic over a small set of preloaded lines
      for (int i = 0; i < 8; i++) txn(0, 1, 16'(16'h1000 + (i << 4)), rnd128(), 0);
      for (int t = 0; t < 60; t++) begin
         rd = $urandom_range(0, 1) == 1;
         wr = !rd || ($urandom_range(0, 9) == 0);
         addr = 16'(16'h1000 + ($urandom_range(0, 7) << 4) + $urandom_range(0, 15));
         txn(rd, wr, addr, rnd128(), $urandom_range(0, 3) == 0);
      end
      chk("final_error", 128'(pmem_error), 128'(err_exp));
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
